// File: rtl/main_mem_pkg.sv
// Shared constants and types for the backing-memory controller and its client.
// Line geometry is imported by cache_controller as well, so keep it stable.
package main_mem_pkg;

  localparam int unsigned WORD_BITS   = 32;
  localparam int unsigned LINE_WORDS  = 16;
  localparam int unsigned LINE_BITS   = LINE_WORDS * WORD_BITS;
  localparam int unsigned OFFSET_BITS = 6;
  localparam int unsigned BEAT_BITS   = 4;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    BURST,
    WRITE,
    HOLD
  } mm_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } mm_op_t;

endpackage

// File: rtl/main_mem_if.sv
// Main-memory port between cache_controller (master) and main_mem_ctrl (slave).
//   req_addr  : byte address          req_wdata : store data
//   read_req  : line-fill request     write_req : word-store request
//   line_data : filled 512-bit line   ready     : one-cycle completion pulse
//   busy      : controller not idle
interface main_mem_if;
  import main_mem_pkg::*;

  logic [31:0]            req_addr;
  logic [WORD_BITS-1:0]   req_wdata;
  logic                   read_req;
  logic                   write_req;
  logic [LINE_BITS-1:0]   line_data;
  logic                   ready;
  logic                   busy;

  modport master (
    output req_addr, req_wdata, read_req, write_req,
    input  line_data, ready, busy
  );

  modport slave (
    input  req_addr, req_wdata, read_req, write_req,
    output line_data, ready, busy
  );

endinterface

// File: rtl/main_mem_array.sv
// Single-port word RAM: combinational read, synchronous write.
//   clk   : clock            we    : write enable
//   addr  : word index       wdata : write data
//   rdata : read data (combinational)
// Each cell stores its word XOR-ed with the word's own byte address, so a blank
// (all-zero) array reads back as the default image word k = k*4. A preload file
// for synthesis must therefore be encoded as (word ^ byte_address).
module main_mem_array #(
  parameter  int unsigned WORDS = 4096,
  localparam int unsigned AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS] = '{default: '0};

  // Byte address of a word: the value the default image holds there.
  function automatic logic [31:0] image(input logic [AW-1:0] a);
    return 32'({a, 2'b00});
  endfunction

  assign rdata = mem[addr] ^ image(addr);

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata ^ image(addr);
  end

endmodule

// File: rtl/main_mem_ctrl.sv
// Backing-memory controller: 16-beat line fills and single-word stores with a
// programmable access latency and a one-cycle ready pulse per transaction.
//   clk : rising-edge clock    rst : synchronous active-high reset
//   bus : main-memory port (slave side), see main_mem_if
module main_mem_ctrl #(
  parameter int unsigned WORDS      = 4096,
  parameter int unsigned ACCESS_LAT = 3
) (
  input logic       clk,
  input logic       rst,
  main_mem_if.slave bus
);
  import main_mem_pkg::*;

  localparam int unsigned AW = $clog2(WORDS);
  localparam int unsigned CW = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;

  mm_state_t                              state_q, state_d;
  mm_op_t                                 op_q, op_d;
  logic [AW-1:0]                          addr_q, addr_d;
  logic [WORD_BITS-1:0]                   wdata_q, wdata_d;
  logic [CW-1:0]                          cnt_q, cnt_d;
  logic [BEAT_BITS-1:0]                   beat_q, beat_d;
  logic [LINE_WORDS-1:0][WORD_BITS-1:0]   line_data_q, line_data_d;
  logic                                   ready_q, ready_d;
  logic                                   busy_q, busy_d;

  logic [AW-1:0]        mem_addr_c;
  logic                 mem_we_c;
  logic [WORD_BITS-1:0] mem_rdata_c;
  logic                 unused_addr_bits_c;

  // Aliasing: address bits above the array and the byte offset are ignored.
  assign unused_addr_bits_c = ^{bus.req_addr[31:AW+2], bus.req_addr[1:0]};

  // Bursts walk the latched line base; stores use the latched word index.
  // A reset edge suppresses an in-flight store so the array stays untouched.
  assign mem_addr_c = (state_q == WRITE) ? addr_q
                                         : {addr_q[AW-1:BEAT_BITS], beat_q};
  assign mem_we_c   = (state_q == WRITE) && !rst;

  main_mem_array #(.WORDS(WORDS)) u_array (
    .clk   (clk),
    .we    (mem_we_c),
    .addr  (mem_addr_c),
    .wdata (wdata_q),
    .rdata (mem_rdata_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= OP_READ;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      beat_q      <= '0;
      line_data_q <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      line_data_q <= line_data_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    beat_d      = beat_q;
    line_data_d = line_data_q;
    ready_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Read has priority; an unserved write stays pending at the master.
        if (bus.read_req) begin
          addr_d  = {bus.req_addr[AW+1:OFFSET_BITS], BEAT_BITS'(0)};
          op_d    = OP_READ;
          cnt_d   = '0;
          state_d = WAIT;
        end else if (bus.write_req) begin
          addr_d  = bus.req_addr[AW+1:2];
          wdata_d = bus.req_wdata;
          op_d    = OP_WRITE;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CW'(ACCESS_LAT - 1)) begin
          cnt_d   = '0;
          beat_d  = '0;
          state_d = (op_q == OP_READ) ? BURST : WRITE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BURST: begin
        line_data_d[beat_q] = mem_rdata_c;
        if (beat_q == BEAT_BITS'(LINE_WORDS - 1)) begin
          beat_d  = '0;
          ready_d = 1'b1;
          state_d = HOLD;
        end else begin
          beat_d = beat_q + BEAT_BITS'(1);
        end
      end
      WRITE: begin
        ready_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        // One dead cycle so a request held across ready is not re-accepted.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.line_data = line_data_q;
  assign bus.ready     = ready_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Self-checking bench for main_mem_ctrl against a word-array reference model.
module tb_main_mem_ctrl;
  import main_mem_pkg::*;

  localparam int unsigned WORDS  = 4096;
  localparam int unsigned LAT    = 3;
  localparam int          RD_LAT = LAT + 16;
  localparam int          WR_LAT = LAT + 1;

  typedef logic [LINE_BITS-1:0] line_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  main_mem_if bus();

  main_mem_ctrl #(.WORDS(WORDS), .ACCESS_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passed = 0;
  logic [31:0] ref_mem [WORDS];

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'(WORDS - 1));
  endfunction

  function automatic line_t exp_line(input logic [31:0] a);
    line_t l;
    int base;
    base = widx(a) & ~15;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = ref_mem[base + i];
    return l;
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!bus.busy && !bus.ready) return;
      @(posedge clk); #1;
    end
    checks++;
    $display("FAIL wait_idle: busy=%0b still high after 200 cycles", bus.busy);
  endtask

  task automatic run_read(input logic [31:0] a, input bit hold, output int lat, output line_t line);
    @(negedge clk); bus.req_addr = a; bus.read_req = 1'b1;
    @(posedge clk);
    @(negedge clk); if (!hold) bus.read_req = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (bus.ready) begin lat = n; break; end
    end
    line = bus.line_data;
  endtask

  task automatic run_write(input logic [31:0] a, input logic [31:0] d, output int lat);
    @(negedge clk); bus.req_addr = a; bus.req_wdata = d; bus.write_req = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.write_req = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (bus.ready) begin lat = n; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", bus.ready); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
    checks++; if (bus.line_data !== '0) $display("FAIL reset_line: got %h want 0", bus.line_data); else passed++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_read_fill();
    int lat; line_t line;
    run_read(32'h1000, 1'b0, lat, line);
    checks++; if (lat !== RD_LAT) $display("FAIL fill_latency: got %0d want %0d", lat, RD_LAT); else passed++;
    checks++; if (line !== exp_line(32'h1000)) $display("FAIL fill_line: got %h want %h", line, exp_line(32'h1000)); else passed++;
    checks++; if (line[31:0] !== 32'h1000) $display("FAIL fill_word0: got %h want 00001000", line[31:0]); else passed++;
    checks++; if (line[511:480] !== 32'h103C) $display("FAIL fill_word15: got %h want 0000103c", line[511:480]); else passed++;
    @(posedge clk); #1;
    checks++; if (bus.ready !== 1'b0) $display("FAIL fill_ready_pulse: got %b want 0", bus.ready); else passed++;
    checks++; if (bus.line_data !== line) $display("FAIL fill_line_hold: got %h want %h", bus.line_data, line); else passed++;
    wait_idle();
  endtask

  task automatic test_unaligned_read();
    int lat; line_t line;
    run_read(32'h2008, 1'b0, lat, line);
    checks++; if (lat !== RD_LAT) $display("FAIL unaligned_latency: got %0d want %0d", lat, RD_LAT); else passed++;
    checks++; if (line !== exp_line(32'h2000)) $display("FAIL unaligned_line: got %h want %h", line, exp_line(32'h2000)); else passed++;
    checks++; if (line[31:0] !== 32'h2000) $display("FAIL unaligned_word0: got %h want 00002000", line[31:0]); else passed++;
    wait_idle();
  endtask

  task automatic test_write_then_read();
    int lat; line_t line;
    run_write(32'h2004, 32'hDEADBEEF, lat);
    ref_mem[widx(32'h2004)] = 32'hDEADBEEF;
    checks++; if (lat !== WR_LAT) $display("FAIL write_latency: got %0d want %0d", lat, WR_LAT); else passed++;
    wait_idle();
    run_read(32'h2000, 1'b0, lat, line);
    checks++; if (line[63:32] !== 32'hDEADBEEF) $display("FAIL wr_rd_word1: got %h want deadbeef", line[63:32]); else passed++;
    checks++; if (line[95:64] !== 32'h2008) $display("FAIL wr_rd_word2: got %h want 00002008", line[95:64]); else passed++;
    checks++; if (line !== exp_line(32'h2000)) $display("FAIL wr_rd_line: got %h want %h", line, exp_line(32'h2000)); else passed++;
    wait_idle();
    // Upper address bits alias onto the same word.
    run_write(32'h2004 + 32'(WORDS * 4 * 3), 32'h0BADF00D, lat);
    ref_mem[widx(32'h2004)] = 32'h0BADF00D;
    wait_idle();
    run_read(32'h2000, 1'b0, lat, line);
    checks++; if (line[63:32] !== 32'h0BADF00D) $display("FAIL alias_word1: got %h want 0badf00d", line[63:32]); else passed++;
    wait_idle();
  endtask

  task automatic test_held_request();
    int lat; int pulses; line_t line;
    run_read(32'h2040, 1'b1, lat, line);
    checks++; if (lat !== RD_LAT) $display("FAIL held_latency: got %0d want %0d", lat, RD_LAT); else passed++;
    checks++; if (line !== exp_line(32'h2040)) $display("FAIL held_line: got %h want %h", line, exp_line(32'h2040)); else passed++;
    @(posedge clk); #1;
    checks++; if (bus.ready !== 1'b0 || bus.busy !== 1'b0) $display("FAIL held_hold_exit: ready=%b busy=%b want 0 0", bus.ready, bus.busy); else passed++;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b1) $display("FAIL held_reaccept: busy=%b want 1", bus.busy); else passed++;
    @(posedge clk);
    @(negedge clk); bus.read_req = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.ready) pulses++;
    end
    checks++; if (pulses !== 1) $display("FAIL held_pulses: got %0d want 1", pulses); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL held_idle: busy=%b want 0", bus.busy); else passed++;
  endtask

  task automatic test_simultaneous();
    int lat; line_t line;
    logic [31:0] a;
    a = 32'h3010;
    wait_idle();
    @(negedge clk); bus.req_addr = a; bus.req_wdata = 32'hA5A50F0F; bus.read_req = 1'b1; bus.write_req = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.read_req = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (bus.ready) begin lat = n; break; end
    end
    checks++; if (lat !== RD_LAT) $display("FAIL simul_read_latency: got %0d want %0d", lat, RD_LAT); else passed++;
    checks++; if (bus.line_data[159:128] !== 32'h3010) $display("FAIL simul_old_word: got %h want 00003010", bus.line_data[159:128]); else passed++;
    checks++; if (bus.line_data !== exp_line(a)) $display("FAIL simul_line: got %h want %h", bus.line_data, exp_line(a)); else passed++;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) $display("FAIL simul_hold_exit: busy=%b want 0", bus.busy); else passed++;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b1) $display("FAIL simul_write_accept: busy=%b want 1", bus.busy); else passed++;
    @(negedge clk); bus.write_req = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (bus.ready) begin lat = n; break; end
    end
    checks++; if (lat !== WR_LAT) $display("FAIL simul_write_latency: got %0d want %0d", lat, WR_LAT); else passed++;
    ref_mem[widx(a)] = 32'hA5A50F0F;
    wait_idle();
    run_read(a, 1'b0, lat, line);
    checks++; if (line[159:128] !== 32'hA5A50F0F) $display("FAIL simul_new_word: got %h want a5a50f0f", line[159:128]); else passed++;
    wait_idle();
  endtask

  task automatic test_reset_mid_op();
    int lat; line_t line;
    // Reset landing on beat 7 of a fill.
    wait_idle();
    @(negedge clk); bus.req_addr = 32'h1040; bus.read_req = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.read_req = 1'b0;
    for (int k = 0; k < LAT + 7; k++) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b1 || bus.line_data[31:0] !== 32'h1040) $display("FAIL rst_burst_pre: busy=%b word0=%h want 1 00001040", bus.busy, bus.line_data[31:0]); else passed++;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0 || bus.ready !== 1'b0) $display("FAIL rst_burst_ctrl: busy=%b ready=%b want 0 0", bus.busy, bus.ready); else passed++;
    checks++; if (bus.line_data !== '0) $display("FAIL rst_burst_line: got %h want 0", bus.line_data); else passed++;
    @(negedge clk); rst = 1'b0;
    run_read(32'h1040, 1'b0, lat, line);
    checks++; if (lat !== RD_LAT) $display("FAIL rst_refill_latency: got %0d want %0d", lat, RD_LAT); else passed++;
    checks++; if (line !== exp_line(32'h1040)) $display("FAIL rst_refill_line: got %h want %h", line, exp_line(32'h1040)); else passed++;
    wait_idle();
    // Reset landing on the store edge: array must be left unmodified.
    @(negedge clk); bus.req_addr = 32'h1044; bus.req_wdata = 32'h12345678; bus.write_req = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.write_req = 1'b0;
    for (int k = 0; k < LAT; k++) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0 || bus.ready !== 1'b0) $display("FAIL rst_write_ctrl: busy=%b ready=%b want 0 0", bus.busy, bus.ready); else passed++;
    @(negedge clk); rst = 1'b0;
    run_read(32'h1040, 1'b0, lat, line);
    checks++; if (line[63:32] !== 32'h1044) $display("FAIL rst_write_abandoned: got %h want 00001044", line[63:32]); else passed++;
    wait_idle();
  endtask

  task automatic test_random();
    int lat; line_t line;
    logic [31:0] r, a, d;
    for (int it = 0; it < 24; it++) begin
      r = $urandom();
      a = (r & 32'hFFFF_C000) | (32'h2000 + ($urandom_range(0, 127) << 2) + $urandom_range(0, 3));
      d = $urandom();
      if ($urandom_range(0, 1) == 0) begin
        run_write(a, d, lat);
        ref_mem[widx(a)] = d;
        checks++; if (lat !== WR_LAT) $display("FAIL rand_write_latency it=%0d: got %0d want %0d", it, lat, WR_LAT); else passed++;
      end else begin
        run_read(a, 1'b0, lat, line);
        checks++; if (lat !== RD_LAT) $display("FAIL rand_read_latency it=%0d: got %0d want %0d", it, lat, RD_LAT); else passed++;
        checks++; if (line !== exp_line(a)) $display("FAIL rand_read_line it=%0d addr=%h: got %h want %h", it, a, line, exp_line(a)); else passed++;
      end
      wait_idle();
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.read_req  = 1'b0;
    bus.write_req = 1'b0;
    for (int k = 0; k < int'(WORDS); k++) ref_mem[k] = 32'(k * 4);

    test_reset();
    test_read_fill();
    test_unaligned_read();
    test_write_then_read();
    test_held_request();
    test_simultaneous();
    test_reset_mid_op();
    test_random();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
